// File: rtl/seg7_scan_display_if.sv
// Bundle between a hex-word source and the multiplexed seven-segment scanner.
// The master drives the source words and display controls; the slave drives the pins.
interface seg7_if #(
  parameter int DIGITS   = 4,
  parameter int CHANNELS = 3
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*DIGITS*4-1:0] ch_data;
  logic [SEL_W-1:0]             ch_sel;
  logic                         enable;
  logic                         lz_blank;
  logic                         blink_en;
  logic [DIGITS-1:0]            dp_mask;
  logic [DIGITS-1:0]            an;
  logic [6:0]                   seg;
  logic                         dp;

  modport master (
    output ch_data, ch_sel, enable, lz_blank, blink_en, dp_mask,
    input  an, seg, dp
  );

  modport slave (
    input  ch_data, ch_sel, enable, lz_blank, blink_en, dp_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode hex display: per-frame source snapshot, digit scan,
// leading-zero blanking, decimal points and frame-synchronous blink.
module seg7_scan_display #(
  parameter int DIGITS       = 4,
  parameter int CHANNELS     = 3,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic  clk,
  input  logic  reset,
  seg7_if.slave bus
);
  localparam int WORD_W  = DIGITS * 4;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TICK_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]         SEG_DARK   = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  logic [TICK_W-1:0]  tick_cnt_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic [FRAME_W-1:0] frame_cnt_p0;
  logic               blink_phase_p0;
  logic [WORD_W-1:0]  snap_p0;

  logic [DIGITS-1:0]  an_p1;
  logic [6:0]         seg_p1;
  logic               dp_p1;

  logic               tick_term;
  logic               frame_bnd;
  logic               dark;
  logic [WORD_W-1:0]  sel_word;
  logic [DIGITS-1:0]  lead_zero;
  logic               zero_run;
  logic [3:0]         cur_nib;
  logic               cur_blank;
  logic               cur_dp;
  logic [DIGITS-1:0]  cur_an;

  assign tick_term = (tick_cnt_p0 == TICK_LAST);
  assign frame_bnd = tick_term && (idx_p0 == IDX_LAST);
  assign dark      = !bus.enable || (bus.blink_en && blink_phase_p0);

  // Out-of-range selects fall through to the all-zero default.
  always_comb begin
    sel_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(bus.ch_sel) == c) sel_word = bus.ch_data[c*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_run     = zero_run && (snap_p0[d*4 +: 4] == 4'h0);
      lead_zero[d] = zero_run;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    cur_an    = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (int'(idx_p0) == d) begin
        cur_nib   = snap_p0[d*4 +: 4];
        cur_blank = bus.lz_blank && (d != 0) && lead_zero[d];
        cur_dp    = bus.dp_mask[d];
        cur_an[d] = 1'b0;
      end
    end
  end

  // p0: scan counters and the frame snapshot; p1: registered pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_p0    <= '0;
      idx_p0         <= '0;
      frame_cnt_p0   <= '0;
      blink_phase_p0 <= 1'b0;
      snap_p0        <= '0;
      an_p1          <= '1;
      seg_p1         <= SEG_DARK;
      dp_p1          <= 1'b1;
    end else begin
      tick_cnt_p0 <= tick_term ? '0 : tick_cnt_p0 + 1'b1;
      if (tick_term) idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      if (frame_bnd) begin
        snap_p0 <= sel_word;
        if (frame_cnt_p0 == FRAME_LAST) begin
          frame_cnt_p0   <= '0;
          blink_phase_p0 <= !blink_phase_p0;
        end else begin
          frame_cnt_p0 <= frame_cnt_p0 + 1'b1;
        end
      end
      if (dark) begin
        an_p1  <= '1;
        seg_p1 <= SEG_DARK;
        dp_p1  <= 1'b1;
      end else begin
        an_p1  <= cur_an;
        seg_p1 <= cur_blank ? SEG_DARK : hex_to_seg(cur_nib);
        dp_p1  <= !cur_dp;
      end
    end
  end

  assign bus.an  = an_p1;
  assign bus.seg = seg_p1;
  assign bus.dp  = dp_p1;
endmodule
